divider_batch_ctrl: RTL and testbench

DIVIDER_BATCH_CTRL -- requirements
Module: divider_batch_ctrl

---
 rtl/divider_pkg.sv | 36 +++
 rtl/divider_en_delay.sv | 27 ++
 rtl/divider_batch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_divider_batch_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants for the divider batch controller: FSM encoding and
// default parameter values.
package divider_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_NUM_DIV    = 8;
  localparam int DEF_LPB        = 2;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_WT_GAP     = 2;
  localparam int DEF_DLY_STAGES = 3;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_LINE_W     = 7;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] ST_RD_ISSUE = 4'd1;
  localparam logic [STATE_W-1:0] ST_RD_WAIT  = 4'd2;
  localparam logic [STATE_W-1:0] ST_RD_RDY   = 4'd3;
  localparam logic [STATE_W-1:0] ST_DIV_EN   = 4'd4;
  localparam logic [STATE_W-1:0] ST_DIV_WAIT = 4'd5;
  localparam logic [STATE_W-1:0] ST_WRITE    = 4'd6;
  localparam logic [STATE_W-1:0] ST_WR_GAP   = 4'd7;
  localparam logic [STATE_W-1:0] ST_NEXT     = 4'd8;
  localparam logic [STATE_W-1:0] ST_DONE     = 4'd9;

  // One shared counter serves read latency, write gap and divider timeout.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/divider_en_delay.sv
// Shift register producing div_en delayed by 1..DLY_STAGES cycles.
module divider_en_delay #(
  parameter int DLY_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  output logic [DLY_STAGES-1:0] dout
);

  logic [DLY_STAGES-1:0] tap_reg;

  for (genvar gi = 0; gi < DLY_STAGES; gi++) begin : g_tap
    always_ff @(posedge clk) begin
      if (!reset) begin
        tap_reg[gi] <= 1'b0;
      end else if (gi == 0) begin
        tap_reg[gi] <= din;
      end else begin
        tap_reg[gi] <= tap_reg[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  assign dout = tap_reg;

endmodule

// File: rtl/divider_batch_ctrl.sv
// Batch controller: reads LPB lines from scratch memory, starts the dividers,
// waits for all of them, then writes back the results line by line.
module divider_batch_ctrl
  import divider_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_DIV    = DEF_NUM_DIV,
  parameter int LPB        = DEF_LPB,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int WT_GAP     = DEF_WT_GAP,
  parameter int DLY_STAGES = DEF_DLY_STAGES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int LINE_W     = DEF_LINE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     rd_base,
  input  logic [ADDR_W-1:0]     wt_base,
  input  logic [LINE_W-1:0]     num_lines,
  input  logic [NUM_DIV-1:0]    div_done,
  output logic [LPB*ADDR_W-1:0] sc_mem_rd_addr,
  output logic                  sc_mem_rd_data_rdy,
  output logic                  div_en,
  output logic [DLY_STAGES-1:0] div_en_dly,
  output logic                  sc_mem_wt_en,
  output logic [ADDR_W-1:0]     sc_mem_wt_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int CNT_W = cnt_width(RD_LAT, WT_GAP, TIMEOUT);
  localparam int LN_W  = LINE_W + 1;

  logic [STATE_W-1:0]    state_reg;
  logic [LN_W-1:0]       line_idx_reg;
  logic [LN_W-1:0]       num_lines_reg;
  logic [LN_W-1:0]       wr_idx_reg;
  logic [ADDR_W-1:0]     rd_base_reg;
  logic [ADDR_W-1:0]     wt_base_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [LPB*ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0]     wt_addr_reg;
  logic                  rd_rdy_reg;
  logic                  div_en_reg;
  logic                  wt_en_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  timeout_reg;

  logic [LPB*ADDR_W-1:0] rd_addr_next;
  logic [LN_W-1:0]       wr_line;
  logic [LN_W-1:0]       line_idx_next;
  logic                  last_wr;
  logic                  last_batch;

  for (genvar gi = 0; gi < LPB; gi++) begin : g_lane
    assign rd_addr_next[gi*ADDR_W +: ADDR_W] =
      rd_base_reg + ADDR_W'(line_idx_reg) + ADDR_W'(gi);
  end

  // A batch stops writing at LPB lines or at the end of the job, whichever is first.
  assign wr_line       = line_idx_reg + wr_idx_reg;
  assign last_wr       = (wr_idx_reg == LN_W'(LPB - 1)) ||
                         ((wr_line + LN_W'(1)) >= num_lines_reg);
  assign line_idx_next = line_idx_reg + LN_W'(LPB);
  assign last_batch    = line_idx_next >= num_lines_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      line_idx_reg  <= '0;
      num_lines_reg <= '0;
      wr_idx_reg    <= '0;
      rd_base_reg   <= '0;
      wt_base_reg   <= '0;
      cnt_reg       <= '0;
      rd_addr_reg   <= '0;
      wt_addr_reg   <= '0;
      rd_rdy_reg    <= 1'b0;
      div_en_reg    <= 1'b0;
      wt_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      // Strobes follow the state one cycle later; abort suppresses them at once.
      rd_rdy_reg <= (state_reg == ST_RD_RDY) && !abort;
      div_en_reg <= (state_reg == ST_DIV_EN) && !abort;
      wt_en_reg  <= (state_reg == ST_WRITE)  && !abort;
      done_reg   <= (state_reg == ST_DONE)   && !abort;
      busy_reg   <= (state_reg != ST_IDLE)   && !abort;

      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            rd_base_reg   <= rd_base;
            wt_base_reg   <= wt_base;
            num_lines_reg <= LN_W'(num_lines);
            line_idx_reg  <= '0;
            timeout_reg   <= 1'b0;
            state_reg     <= (num_lines == '0) ? ST_DONE : ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          rd_addr_reg <= rd_addr_next;
          cnt_reg     <= '0;
          state_reg   <= (RD_LAT == 0) ? ST_RD_RDY : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (cnt_reg == CNT_W'(RD_LAT - 1)) state_reg <= ST_RD_RDY;
          else                               cnt_reg   <= cnt_reg + CNT_W'(1);
        end
        ST_RD_RDY: state_reg <= ST_DIV_EN;
        ST_DIV_EN: begin
          cnt_reg    <= '0;
          wr_idx_reg <= '0;
          state_reg  <= ST_DIV_WAIT;
        end
        ST_DIV_WAIT: begin
          if (&div_done) begin
            state_reg <= ST_WRITE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          wt_addr_reg <= wt_base_reg + ADDR_W'(wr_line);
          cnt_reg     <= '0;
          if (WT_GAP != 0) begin
            state_reg <= ST_WR_GAP;
          end else if (last_wr) begin
            state_reg <= ST_NEXT;
          end else begin
            wr_idx_reg <= wr_idx_reg + LN_W'(1);
          end
        end
        ST_WR_GAP: begin
          if (cnt_reg == CNT_W'(WT_GAP - 1)) begin
            if (last_wr) begin
              state_reg <= ST_NEXT;
            end else begin
              wr_idx_reg <= wr_idx_reg + LN_W'(1);
              state_reg  <= ST_WRITE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          line_idx_reg <= line_idx_next;
          state_reg    <= last_batch ? ST_DONE : ST_RD_ISSUE;
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase

      if (abort && (state_reg != ST_IDLE)) state_reg <= ST_IDLE;
    end
  end

  divider_en_delay #(
    .DLY_STAGES(DLY_STAGES)
  ) u_en_delay (
    .clk  (clk),
    .reset(reset),
    .din  (div_en_reg),
    .dout (div_en_dly)
  );

  assign sc_mem_rd_addr     = rd_addr_reg;
  assign sc_mem_rd_data_rdy = rd_rdy_reg;
  assign div_en             = div_en_reg;
  assign sc_mem_wt_en       = wt_en_reg;
  assign sc_mem_wt_addr     = wt_addr_reg;
  assign busy               = busy_reg;
  assign done               = done_reg;
  assign timeout_err        = timeout_reg;

endmodule

// File: tb/tb_divider_batch_ctrl.sv
// Directed bench for divider_batch_ctrl: a table of jobs with hand-computed
// addresses and strobe counts, plus hand-written abort/reset sequences.
module tb_divider_batch_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] rd_base = '0;
  logic [15:0] wt_base = '0;
  logic [6:0]  num_lines = '0;
  logic [7:0]  div_done = '0;
  logic [31:0] rd_addr;
  logic        rdy, den, wen, busy, done, tmo;
  logic [2:0]  dly;
  logic [15:0] wt_addr;

  always #5 clk = ~clk;

  divider_batch_ctrl #(
    .ADDR_W(16), .NUM_DIV(8), .LPB(2), .RD_LAT(2), .WT_GAP(2),
    .DLY_STAGES(3), .TIMEOUT(TMO), .LINE_W(7)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_base(rd_base), .wt_base(wt_base), .num_lines(num_lines),
    .div_done(div_done), .sc_mem_rd_addr(rd_addr), .sc_mem_rd_data_rdy(rdy),
    .div_en(den), .div_en_dly(dly), .sc_mem_wt_en(wen), .sc_mem_wt_addr(wt_addr),
    .busy(busy), .done(done), .timeout_err(tmo)
  );

  typedef struct {
    logic [15:0]       rd_base;
    logic [15:0]       wt_base;
    logic [6:0]        num;
    int                dly;      // div_done delay after div_en, -1 = stuck low
    bit                abort_wr; // abort in the gap after the first write
    bit                chk_dly;  // check div_en_dly tap timing
    int                n_rd;
    logic [5:0][15:0]  rd_exp;   // lane0, lane1 per batch, first 6 entries
    int                n_wr;
    logic [5:0][15:0]  wr_exp;   // first 6 write addresses
    int                n_done;
    bit                tmo;
  } vec_t;

  vec_t vecs[10];
  int   n_checks = 0;
  int   n_pass = 0;
  int   hits;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [5:0][15:0] pk(input logic [15:0] a0, a1, a2, a3, a4, a5);
    logic [5:0][15:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5;
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] rb, wb, input logic [6:0] n, input int d,
                              input bit ab, cd, input int nr, input logic [5:0][15:0] re,
                              input int nw, input logic [5:0][15:0] we, input int nd, input bit t);
    vec_t v;
    v.rd_base = rb; v.wt_base = wb; v.num = n; v.dly = d; v.abort_wr = ab; v.chk_dly = cd;
    v.n_rd = nr; v.rd_exp = re; v.n_wr = nw; v.wr_exp = we; v.n_done = nd; v.tmo = t;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int idx);
    int cyc, done_cyc, den_cyc, tmo_cyc, abort_cyc, end_cyc, cd;
    int n_rdy, n_den, n_wen, n_done, rd_i, wr_i;
    int rise[3];
    logic [5:0][15:0] rd_cap, wr_cap;
    done_cyc = -1; den_cyc = -1; tmo_cyc = -1; abort_cyc = -1; end_cyc = -1; cd = -1;
    n_rdy = 0; n_den = 0; n_wen = 0; n_done = 0; rd_i = 0; wr_i = 0;
    rise[0] = -1; rise[1] = -1; rise[2] = -1;
    rd_cap = '0; wr_cap = '0;
    @(posedge clk); #1;
    rd_base = v.rd_base; wt_base = v.wt_base; num_lines = v.num; div_done = '0; start = 1'b1;
    for (cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (rdy) begin
        n_rdy++;
        if (rd_i < 6) rd_cap[rd_i] = rd_addr[15:0];
        if (rd_i + 1 < 6) rd_cap[rd_i + 1] = rd_addr[31:16];
        rd_i += 2;
      end
      if (wen) begin
        n_wen++;
        if (wr_i < 6) wr_cap[wr_i] = wt_addr;
        wr_i++;
      end
      if (den) begin
        n_den++;
        if (den_cyc < 0) den_cyc = cyc;
        div_done = '0;
        cd = v.dly;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) div_done = '1;
      end
      for (int i = 0; i < 3; i++) if (dly[i] && rise[i] < 0) rise[i] = cyc;
      if (tmo && tmo_cyc < 0) tmo_cyc = cyc;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        if (end_cyc < 0) end_cyc = cyc + 2;
      end
      if (abort_cyc > 0 && cyc == abort_cyc + 1) check("busy_after_abort", busy, 1'b0);
      // Stimulus for the next edge
      if (cyc == 3 && v.num != 0) begin
        start = 1'b1; rd_base = 16'h1234; wt_base = 16'h4321; num_lines = 7'h55;
      end
      if (v.abort_wr && wen && abort_cyc < 0) begin
        abort = 1'b1;
        abort_cyc = cyc;
        end_cyc = cyc + 20;
      end
      if (end_cyc > 0 && cyc >= end_cyc) break;
    end
    start = 1'b0; abort = 1'b0; div_done = '0;
    check("rd_rdy_count", n_rdy, v.n_rd);
    check("div_en_count", n_den, v.n_rd);
    check("rd_addr_lanes", rd_cap, v.rd_exp);
    check("wt_en_count", n_wen, v.n_wr);
    check("wt_addr_seq", wr_cap, v.wr_exp);
    check("done_count", n_done, v.n_done);
    check("timeout_err_end", tmo, v.tmo);
    check("busy_end", busy, 1'b0);
    if (v.num == 0) check("done_latency", done_cyc, 2);
    if (v.tmo) check("timeout_cycles", tmo_cyc - den_cyc, TMO);
    if (v.chk_dly) begin
      check("dly_tap0", rise[0] - den_cyc, 1);
      check("dly_tap1", rise[1] - den_cyc, 2);
      check("dly_tap2", rise[2] - den_cyc, 3);
    end
    $display("job %0d: rd_base=%h wt_base=%h lines=%0d rdy=%0d div_en=%0d wt=%0d done=%0d tmo=%b",
             idx, v.rd_base, v.wt_base, v.num, n_rdy, n_den, n_wen, n_done, tmo);
  endtask

  initial begin
    vecs[0] = mk(16'd64, 16'd128, 7'd4, 5, 0, 0, 2, pk(64, 65, 66, 67, 0, 0),
                 4, pk(128, 129, 130, 131, 0, 0), 1, 0);
    vecs[1] = mk(16'd64, 16'd128, 7'd3, 5, 0, 0, 2, pk(64, 65, 66, 67, 0, 0),
                 3, pk(128, 129, 130, 0, 0, 0), 1, 0);
    vecs[2] = mk(16'd64, 16'd128, 7'd0, 5, 0, 0, 0, pk(0, 0, 0, 0, 0, 0),
                 0, pk(0, 0, 0, 0, 0, 0), 1, 0);
    vecs[3] = mk(16'd10, 16'd200, 7'd2, -1, 0, 0, 1, pk(10, 11, 0, 0, 0, 0),
                 0, pk(0, 0, 0, 0, 0, 0), 1, 1);
    vecs[4] = mk(16'd64, 16'd128, 7'd4, 3, 1, 0, 1, pk(64, 65, 0, 0, 0, 0),
                 1, pk(128, 0, 0, 0, 0, 0), 0, 0);
    vecs[5] = mk(16'd64, 16'd128, 7'd4, 3, 0, 0, 2, pk(64, 65, 66, 67, 0, 0),
                 4, pk(128, 129, 130, 131, 0, 0), 1, 0);
    vecs[6] = mk(16'hFFFE, 16'hFFFF, 7'd2, 2, 0, 1, 1, pk(16'hFFFE, 16'hFFFF, 0, 0, 0, 0),
                 2, pk(16'hFFFF, 16'h0000, 0, 0, 0, 0), 1, 0);
    vecs[7] = mk(16'hFFFF, 16'd5, 7'd1, 1, 0, 0, 1, pk(16'hFFFF, 16'h0000, 0, 0, 0, 0),
                 1, pk(5, 0, 0, 0, 0, 0), 1, 0);
    vecs[8] = mk(16'd100, 16'd300, 7'd5, 1, 0, 0, 3, pk(100, 101, 102, 103, 104, 105),
                 5, pk(300, 301, 302, 303, 304, 0), 1, 0);
    vecs[9] = mk(16'd0, 16'd1000, 7'd127, 1, 0, 0, 64, pk(0, 1, 2, 3, 4, 5),
                 127, pk(1000, 1001, 1002, 1003, 1004, 1005), 1, 0);

    // Reset holds everything at zero even with a start request present
    reset = 1'b0; start = 1'b1; rd_base = 16'h00AA; wt_base = 16'h00BB; num_lines = 7'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rd_addr, rdy, den, dly, wen, wt_addr, busy, done, tmo}, '0);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) run_job(vecs[i], i);

    // start and abort together in IDLE: no job
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; num_lines = 7'd4; rd_base = 16'd64; wt_base = 16'd128;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy || rdy || den || wen || done) hits++;
      @(posedge clk); #1;
    end
    check("start_abort_same_cycle", hits, 0);
    $display("seq start+abort: strobe_cycles=%0d", hits);

    // Reset in the middle of a job abandons it without done
    div_done = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("busy_mid_job", busy, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_job", {rd_addr, rdy, den, dly, wen, wt_addr, busy, done, tmo}, '0);
    reset = 1'b1;
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || tmo || busy) hits++;
    end
    check("idle_after_mid_reset", hits, 0);
    $display("seq mid-job reset: activity_cycles=%0d", hits);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
